arp_tx: RTL and testbench

- ARP transmit engine for the 10G Ethernet stack.
- Builds 28-byte ARP request and reply payloads and sends them to the MAC TX layer over a 64-bit AXI-Stream master port. The MAC layer adds the Ethernet header from the user sideband.
- Replies are triggered by the ARP receive path: a peer MAC/IP capture plus a reply strobe. Requests are triggered by the upper layer with a target IP.

---
 rtl/arp_tx_if.sv | 30 +++
 rtl/arp_tx.sv | 176 +++++++++++++++++
 tb/tb_arp_tx.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_tx_if.sv
// ============================================================================
//  Module   : arp_tx_if
//  Purpose  : 64-bit AXI-Stream link from the ARP transmit engine to the
//             MAC TX layer. The user sideband carries the Ethernet header
//             fields the MAC layer needs to prepend.
//  Signals  : data  [63:0] payload, MSB = first byte on the wire
//             user  [79:0] {len[15:0], dst_mac[47:0], ethertype[15:0]}
//             keep  [7:0]  byte enables, MSB-aligned
//             last         final beat of the frame
//             valid        beat valid (source)
//             ready        beat accepted (sink)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arp_tx_if;
   logic [63:0] data;
   logic [79:0] user;
   logic [7:0]  keep;
   logic        last;
   logic        valid;
   logic        ready;

   modport master (output data, output user, output keep, output last,
                   output valid, input ready);
   modport slave  (input data, input user, input keep, input last,
                   input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/arp_tx.sv
// ============================================================================
//  Module   : arp_tx
//  Purpose  : ARP transmit engine. Builds 28-byte ARP request/reply payloads
//             and streams them as four 64-bit beats to the MAC TX layer.
//  Ports    : i_clk / i_rst        clock, synchronous active-high reset
//             i_dymanic_src_ip     new local IP, loaded on i_src_ip_valid
//             i_recv_target_*      peer MAC/IP capture from the ARP receiver
//             i_arp_reply          pulse: queue a reply to the captured peer
//             i_arp_req / _ip      pulse: queue a request for i_arp_req_ip
//             o_busy               frame in progress (LOAD or SEND)
//             m_axis_mac           AXI-Stream master towards the MAC layer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_tx #(
   parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
   parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06
) (
   input  wire logic        i_clk,
   input  wire logic        i_rst,
   input  wire logic [31:0] i_dymanic_src_ip,
   input  wire logic        i_src_ip_valid,
   input  wire logic [47:0] i_recv_target_mac,
   input  wire logic [31:0] i_recv_target_ip,
   input  wire logic        i_recv_target_valid,
   input  wire logic        i_arp_reply,
   input  wire logic [31:0] i_arp_req_ip,
   input  wire logic        i_arp_req,
   output logic             o_busy,
   arp_tx_if.master         m_axis_mac
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] local_ip;
   logic [47:0] peer_mac;
   logic [31:0] peer_ip;
   logic        reply_pend;
   logic        req_pend;
   logic [31:0] req_ip;

   // Frame snapshot, frozen for the whole of SEND
   logic        cur_reply;
   logic [31:0] snap_spa;
   logic [47:0] snap_tha;
   logic [31:0] snap_tpa;
   logic [47:0] snap_dst;
   logic [1:0]  beat;

   logic        start;
   logic        accept;
   logic        clr_reply;
   logic        clr_req;
   logic [15:0] oper;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // ------------------------------------------------------------------------
   // Next state and stream outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt        = state;
      start            = 1'b0;
      accept           = 1'b0;
      oper             = cur_reply ? 16'd2 : 16'd1;
      m_axis_mac.valid = 1'b0;
      m_axis_mac.data  = 64'd0;
      m_axis_mac.keep  = 8'h00;
      m_axis_mac.last  = 1'b0;
      m_axis_mac.user  = 80'd0;

      case (state)
         IDLE: begin
            if (reply_pend || req_pend) begin
               start     = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = SEND;
         end
         SEND: begin
            // valid is a pure function of state, never of ready
            m_axis_mac.valid = 1'b1;
            accept           = m_axis_mac.ready;
            m_axis_mac.user  = {16'd28, snap_dst, 16'h0806};
            m_axis_mac.keep  = 8'hFF;
            case (beat)
               2'd0: m_axis_mac.data = {16'h0001, 16'h0800, 8'd6, 8'd4, oper};
               2'd1: m_axis_mac.data = {P_SRC_MAC_ADDR, snap_spa[31:16]};
               2'd2: m_axis_mac.data = {snap_spa[15:0], snap_tha};
               default: begin
                  m_axis_mac.data = {snap_tpa, 32'd0};
                  m_axis_mac.keep = 8'hF0;
                  m_axis_mac.last = 1'b1;
               end
            endcase
            if (accept && beat == 2'd3) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The pending flag of the frame being loaded drops as it enters SEND.
   // A new pulse on that same edge wins, so it is never lost.
   assign clr_reply = (state == LOAD) &&  cur_reply;
   assign clr_req   = (state == LOAD) && !cur_reply;

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         local_ip   <= P_SRC_IP_ADDR;
         peer_mac   <= 48'd0;
         peer_ip    <= 32'd0;
         reply_pend <= 1'b0;
         req_pend   <= 1'b0;
         req_ip     <= 32'd0;
         cur_reply  <= 1'b0;
         snap_spa   <= 32'd0;
         snap_tha   <= 48'd0;
         snap_tpa   <= 32'd0;
         snap_dst   <= 48'd0;
         beat       <= 2'd0;
         o_busy     <= 1'b0;
      end else begin
         if (i_src_ip_valid) local_ip <= i_dymanic_src_ip;

         if (i_recv_target_valid) begin
            peer_mac <= i_recv_target_mac;
            peer_ip  <= i_recv_target_ip;
         end

         reply_pend <= i_arp_reply | (reply_pend & ~clr_reply);
         req_pend   <= i_arp_req   | (req_pend   & ~clr_req);
         if (i_arp_req) req_ip <= i_arp_req_ip;

         // Reply has priority when both are pending
         if (start) begin
            cur_reply <= reply_pend;
            o_busy    <= 1'b1;
         end

         if (state == LOAD) begin
            snap_spa <= local_ip;
            snap_tha <= cur_reply ? peer_mac : 48'd0;
            snap_tpa <= cur_reply ? peer_ip  : req_ip;
            snap_dst <= cur_reply ? peer_mac : 48'hFFFF_FFFF_FFFF;
            beat     <= 2'd0;
         end

         if (accept) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) o_busy <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_arp_tx.sv
// ============================================================================
//  Module   : tb_arp_tx
//  Purpose  : Self-checking bench for arp_tx. A byte-level ARP frame model
//             predicts every output cycle; directed scenarios pin the model
//             with literal frame contents.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arp_tx;

   localparam logic [31:0] C_LIP = 32'hC0A8_6463;
   localparam logic [47:0] C_MAC = 48'h0102_0304_0506;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dyn_ip = '0;
   logic        src_valid = 1'b0;
   logic [47:0] recv_mac = '0;
   logic [31:0] recv_ip = '0;
   logic        recv_valid = 1'b0;
   logic        reply = 1'b0;
   logic [31:0] req_ip = '0;
   logic        req = 1'b0;
   logic        ready = 1'b1;
   logic        busy;

   arp_tx_if bus ();
   assign bus.ready = ready;

   arp_tx dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_dymanic_src_ip    (dyn_ip),
      .i_src_ip_valid      (src_valid),
      .i_recv_target_mac   (recv_mac),
      .i_recv_target_ip    (recv_ip),
      .i_recv_target_valid (recv_valid),
      .i_arp_reply         (reply),
      .i_arp_req_ip        (req_ip),
      .i_arp_req           (req),
      .o_busy              (busy),
      .m_axis_mac          (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: pending flags plus a 28-byte ARP payload image
   // ------------------------------------------------------------------------
   int          m_ph;       // 0 idle, 1 loading, 2 sending
   int          m_beat;
   logic [31:0] m_lip, m_pip, m_rip;
   logic [47:0] m_pmac, m_dst;
   logic        m_rep, m_req, m_cur;
   logic [7:0]  m_bytes [32];

   task automatic build_frame();
      logic [47:0] tha;
      logic [31:0] tpa;
      tha = m_cur ? m_pmac : 48'd0;
      tpa = m_cur ? m_pip  : m_rip;
      m_dst = m_cur ? m_pmac : 48'hFFFF_FFFF_FFFF;
      m_bytes[0] = 8'h00; m_bytes[1] = 8'h01;
      m_bytes[2] = 8'h08; m_bytes[3] = 8'h00;
      m_bytes[4] = 8'd6;  m_bytes[5] = 8'd4;
      m_bytes[6] = 8'h00; m_bytes[7] = m_cur ? 8'd2 : 8'd1;
      for (int i = 0; i < 6; i++) m_bytes[8 + i]  = C_MAC[47 - 8*i -: 8];
      for (int i = 0; i < 4; i++) m_bytes[14 + i] = m_lip[31 - 8*i -: 8];
      for (int i = 0; i < 6; i++) m_bytes[18 + i] = tha[47 - 8*i -: 8];
      for (int i = 0; i < 4; i++) m_bytes[24 + i] = tpa[31 - 8*i -: 8];
      for (int i = 28; i < 32; i++) m_bytes[i] = 8'h00;
   endtask

   always @(posedge clk) begin
      logic clr_rep, clr_req;
      if (rst) begin
         m_ph = 0; m_beat = 0; m_lip = C_LIP; m_pip = 0; m_pmac = 0;
         m_rip = 0; m_rep = 0; m_req = 0; m_cur = 0;
      end else begin
         clr_rep = 1'b0;
         clr_req = 1'b0;
         if (m_ph == 0) begin
            if (m_rep || m_req) begin
               m_cur = m_rep;
               m_ph  = 1;
            end
         end else if (m_ph == 1) begin
            build_frame();
            clr_rep = m_cur;
            clr_req = !m_cur;
            m_ph    = 2;
            m_beat  = 0;
         end else if (ready) begin
            if (m_beat == 3) m_ph = 0;
            else m_beat++;
         end
         if (src_valid) m_lip = dyn_ip;
         if (recv_valid) begin m_pmac = recv_mac; m_pip = recv_ip; end
         m_rep = reply | (m_rep & ~clr_rep);
         m_req = req   | (m_req & ~clr_req);
         if (req) m_rip = req_ip;
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      logic [63:0] ed;
      chk("valid", bus.valid, m_ph == 2);
      chk("busy", busy, m_ph != 0);
      if (m_ph == 2) begin
         ed = '0;
         for (int k = 0; k < 8; k++) ed = {ed[55:0], m_bytes[m_beat*8 + k]};
         chk("data", bus.data, ed);
         chk("keep", bus.keep, (m_beat == 3) ? 8'hF0 : 8'hFF);
         chk("last", bus.last, m_beat == 3);
         chk("user", bus.user, {16'd28, m_dst, 16'h0806});
      end
   end

   // Accepted-beat log and hold-stability check
   logic [63:0] lg_data [$];
   logic [7:0]  lg_keep [$];
   logic        lg_last [$];
   logic [79:0] lg_user [$];
   int          lg_cyc  [$];
   logic        p_valid = 1'b0, p_ready = 1'b0;
   logic [63:0] p_data;
   logic [79:0] p_user;

   always @(posedge clk) begin
      if (p_valid && !p_ready && bus.valid) begin
         chk("hold_data", bus.data, p_data);
         chk("hold_user", bus.user, p_user);
      end
      if (bus.valid && ready) begin
         lg_data.push_back(bus.data);
         lg_keep.push_back(bus.keep);
         lg_last.push_back(bus.last);
         lg_user.push_back(bus.user);
         lg_cyc.push_back(cyc);
      end
      p_valid = bus.valid && !rst;
      p_ready = ready;
      p_data  = bus.data;
      p_user  = bus.user;
      cyc++;
   end

   task automatic clr_log();
      lg_data.delete(); lg_keep.delete(); lg_last.delete();
      lg_user.delete(); lg_cyc.delete();
   endtask

   task automatic wait_log(input int n, input int budget);
      int k = 0;
      while (lg_data.size() < n && k < budget) begin @(negedge clk); k++; end
      chk("log_count", lg_data.size(), n);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!bus.valid && k < 20) begin @(negedge clk); k++; end
      chk("valid_seen", bus.valid, 1'b1);
   endtask

   task automatic pulse_req(input logic [31:0] ip);
      @(negedge clk); req = 1'b1; req_ip = ip;
      @(negedge clk); req = 1'b0;
   endtask

   task automatic pulse_reply();
      @(negedge clk); reply = 1'b1;
      @(negedge clk); reply = 1'b0;
   endtask

   logic [63:0] req_beats [4];
   logic [6:0]  bp_pat;

   initial begin
      int k;
      req_beats[0] = 64'h0001_0800_0604_0001;
      req_beats[1] = 64'h0102_0304_0506_C0A8;
      req_beats[2] = 64'h6463_0000_0000_0000;
      req_beats[3] = 64'hC0A8_6401_0000_0000;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", bus.data, 64'd0);
      chk("rst_user", bus.user, 80'd0);
      chk("rst_keep_last", {bus.keep, bus.last}, 9'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Request
      clr_log();
      pulse_req(32'hC0A8_6401);
      k = 0;
      while (!bus.valid && k < 10) begin @(negedge clk); k++; end
      chk("req_latency", k, 2);
      wait_log(4, 20);
      for (int i = 0; i < 4 && i < lg_data.size(); i++) begin
         chk("req_data", lg_data[i], req_beats[i]);
         chk("req_keep", lg_keep[i], (i == 3) ? 8'hF0 : 8'hFF);
         chk("req_last", lg_last[i], i == 3);
         chk("req_user", lg_user[i], {16'h001C, 48'hFFFF_FFFF_FFFF, 16'h0806});
      end
      chk("req_consecutive", lg_cyc[3] - lg_cyc[0], 3);

      // Reply
      repeat (3) @(negedge clk);
      clr_log();
      recv_valid = 1'b1; recv_mac = 48'hAABB_CCDD_EEFF; recv_ip = 32'hC0A8_6402;
      @(negedge clk); recv_valid = 1'b0;
      repeat (2) @(negedge clk);
      pulse_reply();
      wait_log(4, 20);
      chk("rep_oper", lg_data[0][15:0], 16'h0002);
      chk("rep_beat2", lg_data[2], 64'h6463_AABB_CCDD_EEFF);
      chk("rep_beat3", lg_data[3], 64'hC0A8_6402_0000_0000);
      chk("rep_dst", lg_user[0][63:16], 48'hAABB_CCDD_EEFF);

      // Backpressure
      repeat (3) @(negedge clk);
      clr_log();
      pulse_req(32'hC0A8_6401);
      wait_valid();
      bp_pat = 7'b1101001;   // applied LSB first: 1,0,0,1,0,1,1
      for (int i = 0; i < 7; i++) begin ready = bp_pat[i]; @(negedge clk); end
      ready = 1'b1;
      wait_log(4, 10);
      for (int i = 0; i < 4 && i < lg_data.size(); i++) chk("bp_data", lg_data[i], req_beats[i]);

      // Collision: reply first, request after the minimum gap
      repeat (3) @(negedge clk);
      clr_log();
      @(negedge clk); req = 1'b1; reply = 1'b1; req_ip = 32'hC0A8_6405;
      @(negedge clk); req = 1'b0; reply = 1'b0;
      wait_log(8, 40);
      chk("col_first_reply", lg_data[0][15:0], 16'h0002);
      chk("col_second_req", lg_data[4][15:0], 16'h0001);
      chk("col_gap", lg_cyc[4] - lg_cyc[3], 3);
      chk("col_tpa", lg_data[7][63:32], 32'hC0A8_6405);

      // Duplicate replies during SEND merge into one extra reply
      repeat (3) @(negedge clk);
      clr_log();
      pulse_reply();
      wait_valid();
      reply = 1'b1; @(negedge clk); reply = 1'b0; @(negedge clk);
      reply = 1'b1; @(negedge clk); reply = 1'b0;
      repeat (30) @(negedge clk);
      chk("dup_count", lg_data.size(), 8);
      chk("dup_oper", lg_data[4][15:0], 16'h0002);

      // Dynamic local IP
      @(negedge clk); src_valid = 1'b1; dyn_ip = 32'h0A00_0001;
      @(negedge clk); src_valid = 1'b0;
      clr_log();
      pulse_req(32'hC0A8_6401);
      wait_log(4, 20);
      chk("dyn_spa_hi", lg_data[1][15:0], 16'h0A00);
      chk("dyn_spa_lo", lg_data[2][63:48], 16'h0001);
      repeat (3) @(negedge clk);
      clr_log();
      ready = 1'b0;
      pulse_req(32'hC0A8_6401);
      wait_valid();
      src_valid = 1'b1; dyn_ip = 32'h0B00_0002;
      @(negedge clk); src_valid = 1'b0; ready = 1'b1;
      wait_log(4, 20);
      chk("dyn_keep_hi", lg_data[1][15:0], 16'h0A00);
      chk("dyn_keep_lo", lg_data[2][63:48], 16'h0001);

      // Reset mid-frame
      repeat (3) @(negedge clk);
      clr_log();
      pulse_req(32'hC0A8_6401);
      k = 0;
      while (lg_data.size() < 2 && k < 30) begin @(negedge clk); k++; end
      chk("mid_beats", lg_data.size(), 2);
      rst = 1'b1; ready = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", bus.valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      rst = 1'b0; ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_no_pending", lg_data.size(), 2);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst        = ($urandom_range(0, 599) == 0);
         src_valid  = ($urandom_range(0, 49) == 0);
         dyn_ip     = $urandom;
         recv_valid = ($urandom_range(0, 9) == 0);
         recv_mac   = {$urandom, $urandom} >> 16;
         recv_ip    = $urandom;
         reply      = ($urandom_range(0, 29) == 0);
         req        = ($urandom_range(0, 29) == 0);
         req_ip     = $urandom;
         ready      = ($urandom_range(0, 9) < 7);
      end
      @(negedge clk);
      rst = 1'b0; src_valid = 1'b0; recv_valid = 1'b0;
      reply = 1'b0; req = 1'b0; ready = 1'b1;
      repeat (30) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
